// File: rtl/right_shift_unit_pkg.sv
// Shared types and constants for the multi-cycle 32-bit right shifter.
// Holds the FSM encoding, datapath widths and the captured-request payload.
package right_shift_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Working set captured on an accepted start; shamt doubles as the down-counter.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
  } shift_req_t;

  // One-bit right shift; the vacated MSB takes the sign bit only for SRA.
  function automatic logic [DATA_W-1:0] shift_right_one(
    input logic [DATA_W-1:0] word,
    input logic              sra
  );
    return {sra & word[DATA_W-1], word[DATA_W-1:1]};
  endfunction

endpackage

// File: rtl/right_shift_unit.sv
// Iterative right shifter: one bit per cycle, SRL or SRA, with a busy/done handshake.
// The result register is loaded on the transition into DONE so it is valid while done is high.
module right_shift_unit
  import right_shift_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  in_32,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [DATA_W-1:0]  out_32,
  output logic               busy,
  output logic               done
);

  state_e     state_q;
  state_e     state_d;
  shift_req_t work_q;
  shift_req_t work_d;
  logic       load_result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (shamt == SHAMT_W'(0)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (work_q.shamt == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_SHIFT: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  // Working-register update: capture in IDLE, shift and count down in SHIFT
  always_comb begin
    work_d = work_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d.data  = in_32;
          work_d.shamt = shamt;
          work_d.arith = arith;
        end
      end
      ST_SHIFT: begin
        work_d.data  = shift_right_one(work_q.data, work_q.arith);
        work_d.shamt = work_q.shamt - SHAMT_W'(1);
      end
      default: begin
        work_d = work_q;
      end
    endcase
  end

  assign load_result = (state_d == ST_DONE) && (state_q != ST_DONE);

  // Datapath registers; out_32 only moves on entry to DONE or on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      out_32 <= '0;
    end else begin
      work_q <= work_d;
      if (load_result) begin
        out_32 <= work_d.data;
      end
    end
  end

endmodule

// File: doc/right_shift_unit.md
RIGHT_SHIFT_UNIT -- requirements
Module: right_shift_unit

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; there are no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a shift; sampled only in IDLE.
REQ-005 in_32  input  32  operand; captured on the accepted start edge.
REQ-006 shamt  input  5  shift amount 0..31; captured with in_32.
REQ-007 arith  input  1  fill bit: 1 = SRA (sign fill), 0 = SRL (zero fill); captured with in_32.
REQ-008 out_32  output  32  result register; holds the last result until the next done.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; out_32 is valid in that cycle.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1: capture in_32, shamt and arith into working registers; count <= shamt; go to DONE if shamt==0, otherwise go to SHIFT.
REQ-013 IDLE with start=0: no state change, and out_32 is held.
REQ-014 SHIFT, each cycle: working >>= 1 with the MSB filled by (arith ? working[31] : 0); count decrements by 1; go to DONE when count==1 before the decrement.
REQ-015 DONE: out_32 <= working result, done=1 for that cycle only, and the next state is IDLE.
REQ-016 Latency: with the accepted start edge as E0, done SHALL be high in the cycle following edge E(shamt).
REQ-017 Latency examples: done is one cycle after start for shamt=0, and 32 cycles after start for shamt=31.
REQ-018 A start asserted while busy=1 (SHIFT or DONE) SHALL be ignored, with no effect on the operation in progress.
REQ-019 Back-to-back: a start in the cycle after done (IDLE) SHALL be accepted, giving a minimum issue interval of shamt+2 cycles.
REQ-020 Input changes after capture SHALL NOT affect the result.
REQ-021 Result rule: out_32 == arith ? (signed in_32 >>> shamt) : (in_32 >> shamt), over the full 32-bit width with no truncation of the fill.
REQ-022 out_32 SHALL change only on a DONE transition or on reset.

Reset
REQ-023 On rst=1 at a clock edge: state <= IDLE, out_32 <= 0, busy=0, done=0, and the working and count registers are cleared.
REQ-024 A reset mid-operation SHALL abort the operation with no done pulse, and no partial result reaches out_32.
REQ-025 rst SHALL take priority over start in the same cycle.

Structure
REQ-026 The shared package SHALL hold the state encoding (IDLE/SHIFT/DONE), the data width constant (32) and the shift-amount width constant (5).
REQ-027 The block SHALL be a single module (FSM, 5-bit down-counter, 32-bit working register) with no sub-modules.
REQ-028 done and busy SHALL be decoded from state and SHALL be glitch-free registered-state decodes.

Verification
REQ-029 SRL: in_32=0xF0000000, shamt=4, arith=0 -> done 5 cycles after start, out_32=0x0F000000, busy high for cycles 1..5.
REQ-030 SRA boundary: in_32=0x80000000, shamt=31, arith=1 -> done 32 cycles after start, out_32=0xFFFFFFFF.
REQ-031 Zero shift: in_32=0x12345678, shamt=0 -> done in the next cycle, out_32=0x12345678; the same operand with arith=1 gives the same result.
REQ-032 Ignored start: start in_32=0x00000100, shamt=8, arith=0, then pulse start with in_32=0xFFFFFFFF at cycle 3 -> a single done at cycle 9 with out_32=0x00000001.
REQ-033 Reset mid-op: start shamt=10, assert rst at cycle 4 -> busy=0 and out_32=0 from the next cycle, with no done pulse.
REQ-034 Back-to-back: start (0x00000080, 7, SRL), then start again the cycle after done with (0x80000000, 1, SRA) -> first out_32=0x00000001, second out_32=0xC0000000.
